// File: rtl/switch_debounce_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// switch_debounce_irq_ctrl_if
// Avalon-MM slave bus bundle for the switch debounce / interrupt controller.
//   address    [1:0]  register word select        (master -> slave)
//   chipselect        slave select                (master -> slave)
//   write_n           active-low write strobe     (master -> slave)
//   writedata  [31:0] write data                  (master -> slave)
//   readdata   [31:0] registered read data        (slave  -> master)
// -----------------------------------------------------------------------------
interface switch_debounce_irq_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/switch_debounce_irq_ctrl.sv
// -----------------------------------------------------------------------------
// switch_debounce_irq_ctrl
// Synchronises and debounces WIDTH slide switches, records edges of the
// debounced levels and raises a maskable level interrupt.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   avs      Avalon-MM slave bus (address/chipselect/write_n/writedata/readdata)
//   irq      interrupt request, active high, |(EDGE & MASK)
//   in_port  raw asynchronous switch levels
//
// Register map (word address):
//   0 DATA  RO   debounced state
//   1 MASK  RW   interrupt enable per bit
//   2 EDGE  R/W1C captured edges
//   3 LIMIT RW   prescaler terminal count, bits [15:0]
// -----------------------------------------------------------------------------
module switch_debounce_irq_ctrl #(
  parameter int WIDTH          = 10,
  parameter int DEBOUNCE_RESET = 50000,
  parameter int EDGE_TYPE      = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  switch_debounce_irq_ctrl_if.slave  avs,
  output logic                       irq,
  input  logic [WIDTH-1:0]           in_port
);

  localparam logic [15:0] LIMIT_RST = 16'(DEBOUNCE_RESET);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_state_d;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [15:0]      r_limit;
  logic [15:0]      r_count;
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic             w_wr_limit;
  logic             w_tick;
  logic [WIDTH-1:0] w_state_next;
  logic [WIDTH-1:0] w_edge_event;
  logic [WIDTH-1:0] w_edge_clr;
  logic [WIDTH-1:0] w_edge_next;
  logic [31:0]      w_read_value;

  assign w_wr       = avs.chipselect & ~avs.write_n;
  assign w_wr_mask  = w_wr & (avs.address == 2'd1);
  assign w_wr_edge  = w_wr & (avs.address == 2'd2);
  assign w_wr_limit = w_wr & (avs.address == 2'd3);

  // A LIMIT write restarts the count and suppresses the tick in that cycle,
  // so the next tick lands exactly LIMIT+1 cycles after the write.
  assign w_tick = (r_count == r_limit) & ~w_wr_limit;

  // Edge detection works on the already-registered debounced state, so EDGE
  // sets one cycle after DATA changes.
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_edge_event = r_state & ~r_state_d;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_edge_event = ~r_state & r_state_d;
    end else begin : g_any
      assign w_edge_event = r_state ^ r_state_d;
    end
  endgenerate

  assign w_edge_clr = w_wr_edge ? avs.writedata[WIDTH-1:0] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      // A level is accepted only when two consecutive ticks agree.
      assign w_state_next[gi] = (r_sync2[gi] == r_sample[gi]) ? r_sync2[gi] : r_state[gi];
      // A new capture wins over a simultaneous write-1-to-clear.
      assign w_edge_next[gi]  = (r_edge[gi] & ~w_edge_clr[gi]) | w_edge_event[gi];
    end
  endgenerate

  always_comb begin
    w_read_value = '0;
    case (avs.address)
      2'd0:    w_read_value = 32'(r_state);
      2'd1:    w_read_value = 32'(r_mask);
      2'd2:    w_read_value = 32'(r_edge);
      default: w_read_value = {16'h0000, r_limit};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sample   <= '0;
      r_state    <= '0;
      r_state_d  <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_limit    <= LIMIT_RST;
      r_count    <= '0;
      r_readdata <= '0;
    end else begin
      r_sync1    <= in_port;
      r_sync2    <= r_sync1;
      r_state_d  <= r_state;
      r_edge     <= w_edge_next;
      r_readdata <= w_read_value;

      if (w_tick) begin
        r_sample <= r_sync2;
        r_state  <= w_state_next;
      end

      if (w_wr_limit || w_tick) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 16'd1;
      end

      if (w_wr_mask) begin
        r_mask <= avs.writedata[WIDTH-1:0];
      end

      if (w_wr_limit) begin
        r_limit <= avs.writedata[15:0];
      end
    end
  end

  assign avs.readdata = r_readdata;
  assign irq          = |(r_edge & r_mask);

endmodule

// File: tb/tb_switch_debounce_irq_ctrl.sv
module tb_switch_debounce_irq_ctrl;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic         irq0;
  logic         irq1;
  int           total = 0;
  int           bad = 0;

  switch_debounce_irq_ctrl_if bus0();
  switch_debounce_irq_ctrl_if bus1();

  // Rising-edge build
  switch_debounce_irq_ctrl #(.WIDTH(W), .DEBOUNCE_RESET(50000), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .avs(bus0), .irq(irq0), .in_port(in0));
  // Any-edge build
  switch_debounce_irq_ctrl #(.WIDTH(W), .DEBOUNCE_RESET(50000), .EDGE_TYPE(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .avs(bus1), .irq(irq1), .in_port(in1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] v);
    if (d == 0) begin
      bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.writedata = v;
    end else begin
      bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus1.writedata = v;
    end
    step(1);
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
    $display("write dut%0d addr=%0d data=%h", d, a, v);
  endtask

  task automatic bus_read(input int d, input logic [1:0] a, output logic [31:0] v);
    if (d == 0) bus0.address = a; else bus1.address = a;
    step(1);
    v = (d == 0) ? bus0.readdata : bus1.readdata;
    $display("read  dut%0d addr=%0d data=%h", d, a, v);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_v [4];
    bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
    bus1.address = 2'd0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
    in0 = 10'h3FF; in1 = 10'h3FF;
    reset_n = 1'b0;
    step(3);
    total++;
    if (irq0 !== 1'b0 || bus0.readdata !== 32'h0) begin
      bad++; $display("FAIL reset_hold: got irq=%b rd=%h expected irq=0 rd=0", irq0, bus0.readdata);
    end
    reset_n = 1'b1;
    exp_v[0] = 32'h0; exp_v[1] = 32'h0; exp_v[2] = 32'h0; exp_v[3] = 32'h0000C350;
    for (int a = 0; a < 4; a++) begin
      bus_read(0, 2'(a), v);
      total++;
      if (v !== exp_v[a]) begin
        bad++; $display("FAIL reset_reg%0d: got %h expected %h", a, v, exp_v[a]);
      end
    end
    bus_read(1, 2'd3, v);
    total++;
    if (v !== 32'h0000C350) begin
      bad++; $display("FAIL reset_limit_dut1: got %h expected %h", v, 32'h0000C350);
    end
    total++;
    if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
      bad++; $display("FAIL reset_irq: got %b%b expected 00", irq0, irq1);
    end
    in0 = '0; in1 = '0;
    step(3);
  endtask

  task automatic test_debounce();
    logic [31:0] v;
    int found;
    bus_write(0, 2'd3, 32'd3);
    bus0.address = 2'd0;
    in0 = 10'h001;
    found = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (found == 0 && bus0.readdata === 32'h1) found = k;
    end
    $display("debounce accept seen after %0d cycles", found);
    total++;
    if (found < 8 || found > 11) begin
      bad++; $display("FAIL debounce_latency: got %0d expected 8..11", found);
    end
    bus_read(0, 2'd2, v);
    total++;
    if (v !== 32'h1) begin
      bad++; $display("FAIL debounce_edge: got %h expected %h", v, 32'h1);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    int errs;
    errs = 0;
    bus0.address = 2'd0;
    for (int n = 0; n < 100; n++) begin
      int g;
      g = $urandom_range(5, 12);
      for (int c = 0; c < g; c++) begin
        step(1);
        total++;
        if (bus0.readdata[1] !== 1'b0) begin
          bad++; errs++;
          if (errs < 5) $display("FAIL glitch_data: got %b expected 0", bus0.readdata[1]);
        end
      end
      in0[1] = 1'b1;
      step(3);
      in0[1] = 1'b0;
    end
    step(12);
    bus_read(0, 2'd2, v);
    total++;
    if (v[1] !== 1'b0) begin
      bad++; $display("FAIL glitch_edge: got %b expected 0", v[1]);
    end
    $display("glitch test done: 100 pulses");
  endtask

  task automatic test_irq_mask();
    logic [31:0] v;
    bus_write(0, 2'd2, 32'h3FF);
    in0[2] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      total++;
      if (irq0 !== 1'b0) begin
        bad++; $display("FAIL irq_masked: got %b expected 0", irq0);
      end
    end
    bus_read(0, 2'd2, v);
    total++;
    if (v !== 32'h004) begin
      bad++; $display("FAIL irq_edge_pending: got %h expected %h", v, 32'h004);
    end
    bus_write(0, 2'd1, 32'h004);
    total++;
    if (irq0 !== 1'b1) begin
      bad++; $display("FAIL irq_unmask: got %b expected 1", irq0);
    end
    bus_write(0, 2'd2, 32'h004);
    total++;
    if (irq0 !== 1'b0) begin
      bad++; $display("FAIL irq_clear: got %b expected 0", irq0);
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    bus_write(0, 2'd3, 32'd1000);
    in0[3] = 1'b1;
    step(4);
    // LIMIT=3 written in cycle W: ticks at W+4 and W+8, EDGE sets at end of W+9.
    bus_write(0, 2'd3, 32'd3);
    step(8);
    bus_write(0, 2'd2, 32'h008);
    bus_read(0, 2'd2, v);
    total++;
    if (v !== 32'h008) begin
      bad++; $display("FAIL collision_set_wins: got %h expected %h", v, 32'h008);
    end
    bus_write(0, 2'd2, 32'h000);
    bus_read(0, 2'd2, v);
    total++;
    if (v !== 32'h008) begin
      bad++; $display("FAIL collision_write0: got %h expected %h", v, 32'h008);
    end
    bus_write(0, 2'd2, 32'h008);
    bus_read(0, 2'd2, v);
    total++;
    if (v !== 32'h000) begin
      bad++; $display("FAIL collision_w1c: got %h expected %h", v, 32'h000);
    end
  endtask

  task automatic test_registers();
    logic [31:0] v;
    bus_write(0, 2'd1, 32'hFFFFFFFF);
    bus_read(0, 2'd1, v);
    total++;
    if (v !== 32'h3FF) begin
      bad++; $display("FAIL reg_mask_width: got %h expected %h", v, 32'h3FF);
    end
    bus_write(0, 2'd3, 32'hABCD0007);
    bus_read(0, 2'd3, v);
    total++;
    if (v !== 32'h0007) begin
      bad++; $display("FAIL reg_limit_width: got %h expected %h", v, 32'h0007);
    end
    bus_write(0, 2'd0, 32'hFFFFFFFF);
    bus_read(0, 2'd0, v);
    total++;
    if (v !== 32'(in0)) begin
      bad++; $display("FAIL reg_data_ro: got %h expected %h", v, 32'(in0));
    end
    bus_write(0, 2'd1, 32'h0);
  endtask

  // Rising-edge build against a set-based model of accepted levels and edges.
  task automatic test_random();
    logic [31:0] v;
    logic [W-1:0] mask, model_edge, prev, nv, clr;
    int lim;
    lim  = $urandom_range(0, 4);
    mask = W'($urandom);
    bus_write(0, 2'd3, 32'(lim));
    bus_write(0, 2'd1, 32'(mask));
    step(2 * lim + 10);
    bus_write(0, 2'd2, 32'h3FF);
    model_edge = '0;
    prev = in0;
    for (int n = 0; n < 10; n++) begin
      nv = W'($urandom);
      in0 = nv;
      step(2 * lim + 8);
      model_edge = model_edge | (nv & ~prev);
      prev = nv;
      bus_read(0, 2'd0, v);
      total++;
      if (v !== 32'(nv)) begin
        bad++; $display("FAIL rand_data: got %h expected %h", v, 32'(nv));
      end
      bus_read(0, 2'd2, v);
      total++;
      if (v !== 32'(model_edge)) begin
        bad++; $display("FAIL rand_edge: got %h expected %h", v, 32'(model_edge));
      end
      total++;
      if (irq0 !== |(model_edge & mask)) begin
        bad++; $display("FAIL rand_irq: got %b expected %b", irq0, |(model_edge & mask));
      end
      clr = W'($urandom);
      bus_write(0, 2'd2, 32'(clr));
      model_edge = model_edge & ~clr;
    end
  endtask

  task automatic test_edge_any();
    logic [31:0] v;
    bus_write(1, 2'd3, 32'd0);
    step(4);
    bus_write(1, 2'd2, 32'h3FF);
    in1[9] = 1'b1;
    step(8);
    bus_read(1, 2'd2, v);
    total++;
    if (v !== 32'h200) begin
      bad++; $display("FAIL any_rise_edge: got %h expected %h", v, 32'h200);
    end
    bus_read(1, 2'd0, v);
    total++;
    if (v !== 32'h200) begin
      bad++; $display("FAIL any_rise_data: got %h expected %h", v, 32'h200);
    end
    bus_write(1, 2'd2, 32'h200);
    bus_read(1, 2'd2, v);
    total++;
    if (v !== 32'h0) begin
      bad++; $display("FAIL any_clear: got %h expected %h", v, 32'h0);
    end
    in1[9] = 1'b0;
    step(8);
    bus_read(1, 2'd2, v);
    total++;
    if (v !== 32'h200) begin
      bad++; $display("FAIL any_fall_edge: got %h expected %h", v, 32'h200);
    end
    bus_read(1, 2'd0, v);
    total++;
    if (v !== 32'h0) begin
      bad++; $display("FAIL any_fall_data: got %h expected %h", v, 32'h0);
    end
  endtask

  // Ticks after a LIMIT write at cycle W fall at W+(L+1) and W+2(L+1);
  // the accepted level shows in EDGE (and irq) two cycles after the second.
  task automatic test_tick_timing();
    int lim;
    int exp_k;
    bus_write(1, 2'd1, 32'h200);
    bus_write(1, 2'd2, 32'h3FF);
    bus_write(1, 2'd3, 32'd1000);
    in1[9] = 1'b1;
    step(5);
    lim = $urandom_range(1, 6);
    exp_k = 2 * (lim + 1) + 2;
    bus_write(1, 2'd3, 32'(lim));
    for (int k = 1; k <= exp_k + 2; k++) begin
      total++;
      if (irq1 !== (k >= exp_k)) begin
        bad++; $display("FAIL tick_timing L=%0d k=%0d: got %b expected %b", lim, k, irq1, (k >= exp_k));
      end
      step(1);
    end
    $display("tick timing checked with LIMIT=%0d", lim);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_irq_mask();
    test_collision();
    test_registers();
    test_random();
    test_edge_any();
    test_tick_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
